mem_stage_access: RTL and testbench
===================================

// Module: mem_stage_access
// PURPOSE
//  MEM stage of the 5-stage RISC-V pipeline; consumes the EX/MEM register outputs of the EX stage.
//  Runs loads/stores over a valid/ready data-memory bus and holds the pipeline (mem_stall) until done.
//  Loads the MEM/WB register and returns ALU result/Rd address for forwarding.
// PARAMETERS
//  N        32  datapath / address width
//  RA_W     5   register-address width
// PORTS
//  clk                    in   1     clock; all state on rising edge
//  rst                    in   1     reset, synchronous, active-high
//  en_MemWb               in   1     MEM/WB load enable from hazard control
//  ExMem_RegwriteStage3   in   1     EX/MEM RegWrite
//  ExMem_MemReadStage3    in   1     EX/MEM MemRead
//  ExMem_MemWriteStage3   in   1     EX/MEM MemWrite
//  ExMem_MemtoRegStage3   in   1     EX/MEM MemtoReg
//  ExMem_AluResult_Stage3 in   N     ALU result / effective address
//  ExMem_ReadData2Bypass  in   N     store data
//  ExMem_RdAddStage3      in   RA_W  destination register
//  dmem_req_valid         out  1     bus request valid
//  dmem_req_ready         in   1     bus request accepted
//  dmem_we                out  1     1=store, 0=load
//  dmem_addr              out  N     word address (bits[1:0]=0)
//  dmem_wdata             out  N     store data
//  dmem_rsp_valid         in   1     load data valid
//  dmem_rdata             in   N     load data
//  mem_stall              out  1     freeze PC, IF/ID, ID/EX, EX/MEM
//  mem_misaligned         out  1     1-cycle pulse: access with addr[1:0]!=0
//  ExMem_AluResult_Stage4 out  N     = ExMem_AluResult_Stage3 (comb, to forwarding)
//  ExMem_RdAddStage4      out  RA_W  = ExMem_RdAddStage3 (comb, to forwarding)
//  MemWb_Regwrite         out  1     MEM/WB RegWrite
//  MemWb_MemtoReg         out  1     MEM/WB MemtoReg
//  MemWb_ReadData         out  N     MEM/WB load data
//  MemWb_AluResult        out  N     MEM/WB ALU result
//  MemWb_RdAdd            out  RA_W  MEM/WB destination register
// BEHAVIOUR
//  - Reset: state IDLE; all MemWb_* 0, dmem_req_valid 0, dmem_we 0, dmem_addr/wdata 0,
//    mem_misaligned 0; rst mid-transaction aborts it, no retry; rsp_valid outside RESP ignored.
//  - acc = MemRead|MemWrite; MemRead&MemWrite together treated as store.
//  - FSM IDLE->REQ->(RESP)->DONE->IDLE:
//    IDLE: acc & aligned -> latch addr/we/wdata, go REQ. acc & misaligned -> no bus cycle,
//      pulse mem_misaligned, MEM/WB loads RegWrite forced 0. No acc -> stay, no stall.
//    REQ: dmem_req_valid=1, addr/we/wdata stable until dmem_req_ready.
//      ready&we -> DONE; ready&!we -> RESP.
//    RESP: wait dmem_rsp_valid (>=1 cycle after accept; rsp in REQ ignored);
//      capture dmem_rdata, go DONE.
//    DONE: stall low; if en_MemWb, MEM/WB loads, go IDLE; else hold DONE.
//  - mem_stall = (IDLE & acc & aligned) | REQ | RESP; comb, asserted in the detect cycle.
//  - MEM/WB loads when en_MemWb & !mem_stall; else holds. Non-memory instr: ALU result/Rd/
//    RegWrite/MemtoReg pass in one cycle, MemWb_ReadData unchanged.
//  - Latency: load with ready=1, rsp next cycle -> 3 stall cycles; store with ready=1 -> 2.
//  - No timeout: bus that never responds stalls forever (bus owner's responsibility).
// STRUCTURE
//  - riscv_pkg: N, RA_W, mem_state_t {IDLE,REQ,RESP,DONE}, 2-bit state encoding.
//  - Sub-module mem_req_fsm: state, request latches, bus handshake, stall/misaligned outputs.
//    Top holds MEM/WB register and forwarding pass-through.
// TESTING
//  - ALU op, rd=5, res=0x1234, RegWrite=1 -> next edge MemWb_AluResult=0x1234, Rd=5, stall never high.
//  - Load 0x100, ready=1, rsp 1 cycle later rdata=0xDEADBEEF -> stall 3 cycles,
//    one req_valid cycle, MemWb_ReadData=0xDEADBEEF, MemtoReg=1.
//  - Store 0x200 data 0xA5A5A5A5, ready low 4 cycles -> addr/wdata/we stable throughout,
//    stall 6 cycles total, MemWb_Regwrite=0.
//  - Load to 0x102 -> no req_valid, mem_misaligned 1 cycle, MemWb_Regwrite=0, no stall.
//  - rst in RESP, then late rsp_valid -> IDLE, MEM/WB zeros, rsp ignored, stall low.
//  - en_MemWb=0 in DONE for 2 cycles -> stays DONE, MEM/WB loads once en returns.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V pipeline MEM stage.
package riscv_pkg;

  localparam int N    = 32;
  localparam int RA_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  // Word accesses only: the two low address bits must be zero.
  function automatic logic is_aligned(input logic [1:0] addr_lsbs);
    return addr_lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/mem_req_fsm.sv
// Data-memory access sequencer: request latches, valid/ready handshake,
// load-data capture, pipeline stall and misaligned-access reporting.
module mem_req_fsm #(
  parameter int N = riscv_pkg::N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] wdata,
  input  logic         en_MemWb,
  output logic         dmem_req_valid,
  input  logic         dmem_req_ready,
  output logic         dmem_we,
  output logic [N-1:0] dmem_addr,
  output logic [N-1:0] dmem_wdata,
  input  logic         dmem_rsp_valid,
  input  logic [N-1:0] dmem_rdata,
  output logic [N-1:0] load_data,
  output logic         done_load,
  output logic         misaligned_now,
  output logic         mem_stall,
  output logic         mem_misaligned
);
  import riscv_pkg::*;

  mem_state_t state_q;
  mem_state_t state_d;
  logic       acc;
  logic       aligned;
  logic       start;

  // A simultaneous read+write is treated as a store, so MemWrite alone decides direction.
  assign acc     = mem_read | mem_write;
  assign aligned = is_aligned(addr[1:0]);
  assign start   = (state_q == IDLE) && acc && aligned;

  // Next-state, stall and request-valid decode for the current state.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d        = state_q;
    mem_stall      = 1'b0;
    dmem_req_valid = 1'b0;
    misaligned_now = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc && aligned) begin
          mem_stall = 1'b1;
          state_d   = REQ;
        end else if (acc) begin
          misaligned_now = 1'b1;
        end
      end
      REQ: begin
        mem_stall      = 1'b1;
        dmem_req_valid = 1'b1;
        if (dmem_req_ready) state_d = dmem_we ? DONE : RESP;
      end
      RESP: begin
        mem_stall = 1'b1;
        if (dmem_rsp_valid) state_d = DONE;
      end
      DONE: begin
        if (en_MemWb) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign done_load = (state_q == DONE) && !dmem_we;

  // State register, request latches, load-data capture and misaligned pulse.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q        <= IDLE;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      load_data      <= '0;
      mem_misaligned <= 1'b0;
    end else begin
      state_q <= state_d;
      // Request fields are frozen from detection until the bus accepts them.
      if (start) begin
        dmem_we    <= mem_write;
        dmem_addr  <= addr;
        dmem_wdata <= wdata;
      end
      // Responses outside RESP are not ours and are dropped.
      if (state_q == RESP && dmem_rsp_valid) load_data <= dmem_rdata;
      // Pulse once, in the cycle the faulting instruction reaches MEM/WB.
      mem_misaligned <= misaligned_now && en_MemWb;
    end
  end

endmodule

// File: rtl/mem_stage_access.sv
// MEM stage: data-memory access sequencing, MEM/WB pipeline register and
// forwarding pass-through of the EX/MEM ALU result and destination register.
module mem_stage_access #(
  parameter int N    = riscv_pkg::N,
  parameter int RA_W = riscv_pkg::RA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_MemWb,
  input  logic            ExMem_RegwriteStage3,
  input  logic            ExMem_MemReadStage3,
  input  logic            ExMem_MemWriteStage3,
  input  logic            ExMem_MemtoRegStage3,
  input  logic [N-1:0]    ExMem_AluResult_Stage3,
  input  logic [N-1:0]    ExMem_ReadData2Bypass,
  input  logic [RA_W-1:0] ExMem_RdAddStage3,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_we,
  output logic [N-1:0]    dmem_addr,
  output logic [N-1:0]    dmem_wdata,
  input  logic            dmem_rsp_valid,
  input  logic [N-1:0]    dmem_rdata,
  output logic            mem_stall,
  output logic            mem_misaligned,
  output logic [N-1:0]    ExMem_AluResult_Stage4,
  output logic [RA_W-1:0] ExMem_RdAddStage4,
  output logic            MemWb_Regwrite,
  output logic            MemWb_MemtoReg,
  output logic [N-1:0]    MemWb_ReadData,
  output logic [N-1:0]    MemWb_AluResult,
  output logic [RA_W-1:0] MemWb_RdAdd
);
  import riscv_pkg::*;

  logic [N-1:0] load_data;
  logic         done_load;
  logic         misaligned_now;

  mem_req_fsm #(.N(N)) u_fsm (
    .clk            (clk),
    .rst            (rst),
    .mem_read       (ExMem_MemReadStage3),
    .mem_write      (ExMem_MemWriteStage3),
    .addr           (ExMem_AluResult_Stage3),
    .wdata          (ExMem_ReadData2Bypass),
    .en_MemWb       (en_MemWb),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rdata     (dmem_rdata),
    .load_data      (load_data),
    .done_load      (done_load),
    .misaligned_now (misaligned_now),
    .mem_stall      (mem_stall),
    .mem_misaligned (mem_misaligned)
  );

  assign ExMem_AluResult_Stage4 = ExMem_AluResult_Stage3;
  assign ExMem_RdAddStage4      = ExMem_RdAddStage3;

  // MEM/WB register: advances only when hazard control allows and no access is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      MemWb_Regwrite  <= 1'b0;
      MemWb_MemtoReg  <= 1'b0;
      MemWb_ReadData  <= '0;
      MemWb_AluResult <= '0;
      MemWb_RdAdd     <= '0;
    end else if (en_MemWb && !mem_stall) begin
      // A misaligned access is squashed so it cannot write the register file.
      MemWb_Regwrite  <= ExMem_RegwriteStage3 && !misaligned_now;
      MemWb_MemtoReg  <= ExMem_MemtoRegStage3;
      MemWb_AluResult <= ExMem_AluResult_Stage3;
      MemWb_RdAdd     <= ExMem_RdAddStage3;
      if (done_load) MemWb_ReadData <= load_data;
    end
  end

endmodule

// File: tb/tb_mem_stage_access.sv
// Self-checking bench for mem_stage_access: directed vector table, random
// instruction stream against a behavioural model, and a mid-access reset.
module tb_mem_stage_access;

  typedef struct {
    logic        rw, mr, mw, m2r;
    logic [31:0] alu, wdata, rdata;
    logic [4:0]  rd;
    int          ready_wait, rsp_wait, en_hold;
    logic        junk;
    int          exp_stall, exp_reqs;
    logic        exp_mis, exp_rw;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, en_MemWb;
  logic        ExMem_RegwriteStage3, ExMem_MemReadStage3, ExMem_MemWriteStage3, ExMem_MemtoRegStage3;
  logic [31:0] ExMem_AluResult_Stage3, ExMem_ReadData2Bypass;
  logic [4:0]  ExMem_RdAddStage3;
  logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_stall, mem_misaligned;
  logic [31:0] ExMem_AluResult_Stage4;
  logic [4:0]  ExMem_RdAddStage4;
  logic        MemWb_Regwrite, MemWb_MemtoReg;
  logic [31:0] MemWb_ReadData, MemWb_AluResult;
  logic [4:0]  MemWb_RdAdd;

  int total = 0;
  int bad   = 0;

  // Behavioural view of the MEM/WB register.
  logic        m_rw, m_m2r;
  logic [31:0] m_rdata, m_alu;
  logic [4:0]  m_rd;

  mem_stage_access dut (
    .clk                    (clk),
    .rst                    (rst),
    .en_MemWb               (en_MemWb),
    .ExMem_RegwriteStage3   (ExMem_RegwriteStage3),
    .ExMem_MemReadStage3    (ExMem_MemReadStage3),
    .ExMem_MemWriteStage3   (ExMem_MemWriteStage3),
    .ExMem_MemtoRegStage3   (ExMem_MemtoRegStage3),
    .ExMem_AluResult_Stage3 (ExMem_AluResult_Stage3),
    .ExMem_ReadData2Bypass  (ExMem_ReadData2Bypass),
    .ExMem_RdAddStage3      (ExMem_RdAddStage3),
    .dmem_req_valid         (dmem_req_valid),
    .dmem_req_ready         (dmem_req_ready),
    .dmem_we                (dmem_we),
    .dmem_addr              (dmem_addr),
    .dmem_wdata             (dmem_wdata),
    .dmem_rsp_valid         (dmem_rsp_valid),
    .dmem_rdata             (dmem_rdata),
    .mem_stall              (mem_stall),
    .mem_misaligned         (mem_misaligned),
    .ExMem_AluResult_Stage4 (ExMem_AluResult_Stage4),
    .ExMem_RdAddStage4      (ExMem_RdAddStage4),
    .MemWb_Regwrite         (MemWb_Regwrite),
    .MemWb_MemtoReg         (MemWb_MemtoReg),
    .MemWb_ReadData         (MemWb_ReadData),
    .MemWb_AluResult        (MemWb_AluResult),
    .MemWb_RdAdd            (MemWb_RdAdd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_memwb(input string tag);
    check({tag, " MemWb_Regwrite"},  {31'd0, MemWb_Regwrite}, {31'd0, m_rw});
    check({tag, " MemWb_MemtoReg"},  {31'd0, MemWb_MemtoReg}, {31'd0, m_m2r});
    check({tag, " MemWb_ReadData"},  MemWb_ReadData, m_rdata);
    check({tag, " MemWb_AluResult"}, MemWb_AluResult, m_alu);
    check({tag, " MemWb_RdAdd"},     {27'd0, MemWb_RdAdd}, {27'd0, m_rd});
  endtask

  // Expected outcome from the access rules: word-aligned accesses cost one
  // detect cycle, one cycle per request beat, and for loads the response wait.
  function automatic vec_t fill(input vec_t v);
    logic acc, ok;
    acc = v.mr | v.mw;
    ok  = (v.alu[1:0] == 2'b00);
    v.exp_mis  = acc && !ok;
    v.exp_rw   = v.rw && !(acc && !ok);
    v.exp_reqs = (acc && ok) ? v.ready_wait + 1 : 0;
    if (!(acc && ok))  v.exp_stall = 0;
    else if (v.mw)     v.exp_stall = 2 + v.ready_wait;
    else               v.exp_stall = 3 + v.ready_wait + v.rsp_wait;
    return v;
  endfunction

  // Presents one instruction at EX/MEM, acts as the memory bus, and checks
  // the stage until the instruction has been written into MEM/WB.
  // Entered and left one time unit after a rising edge.
  task automatic run_instr(input string tag, input vec_t v);
    int   stalls = 0, reqs = 0, cyc = 0, since = 0, hold_left;
    logic accepted = 1'b0, rsp_done = 1'b0, finished = 1'b0, acc, ok, is_load;
    hold_left = v.en_hold;
    acc     = v.mr | v.mw;
    ok      = (v.alu[1:0] == 2'b00);
    is_load = !v.mw;
    ExMem_RegwriteStage3   = v.rw;
    ExMem_MemReadStage3    = v.mr;
    ExMem_MemWriteStage3   = v.mw;
    ExMem_MemtoRegStage3   = v.m2r;
    ExMem_AluResult_Stage3 = v.alu;
    ExMem_ReadData2Bypass  = v.wdata;
    ExMem_RdAddStage3      = v.rd;
    while (!finished && cyc < 200) begin
      dmem_req_ready = dmem_req_valid && (reqs >= v.ready_wait);
      if (accepted && is_load && !rsp_done) begin
        dmem_rsp_valid = (since >= v.rsp_wait);
        dmem_rdata     = v.rdata;
        if (dmem_rsp_valid) rsp_done = 1'b1;
        since++;
      end else begin
        dmem_rsp_valid = v.junk;
        dmem_rdata     = ~v.rdata;
      end
      #1;
      if (!mem_stall && hold_left > 0) begin
        en_MemWb = 1'b0;
        hold_left--;
      end else begin
        en_MemWb = 1'b1;
      end
      @(negedge clk);
      if (cyc == 0) begin
        check({tag, " fwd alu"}, ExMem_AluResult_Stage4, v.alu);
        check({tag, " fwd rd"}, {27'd0, ExMem_RdAddStage4}, {27'd0, v.rd});
      end else begin
        check({tag, " misaligned pulse width"}, {31'd0, mem_misaligned}, 32'd0);
      end
      if (mem_stall) stalls++;
      if (dmem_req_valid) begin
        reqs++;
        check({tag, " dmem_addr"},  dmem_addr, v.alu);
        check({tag, " dmem_we"},    {31'd0, dmem_we}, {31'd0, v.mw});
        if (v.mw) check({tag, " dmem_wdata"}, dmem_wdata, v.wdata);
        if (dmem_req_ready) accepted = 1'b1;
      end
      if (!en_MemWb) check_memwb({tag, " hold"});
      finished = !mem_stall && en_MemWb;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!finished) check({tag, " completion within budget"}, 32'd0, 32'd1);
    // MEM/WB has just loaded this instruction.
    m_rw  = v.rw && !(acc && !ok);
    m_m2r = v.m2r;
    m_alu = v.alu;
    m_rd  = v.rd;
    if (acc && ok && is_load) m_rdata = v.rdata;
    check_memwb(tag);
    check({tag, " stall cycles"},   stalls, v.exp_stall);
    check({tag, " request cycles"}, reqs, v.exp_reqs);
    check({tag, " mem_misaligned"}, {31'd0, mem_misaligned}, {31'd0, v.exp_mis});
    check({tag, " regwrite rule"},  {31'd0, MemWb_Regwrite}, {31'd0, v.exp_rw});
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
  endtask

  task automatic drive_nop();
    ExMem_RegwriteStage3   = 1'b0;
    ExMem_MemReadStage3    = 1'b0;
    ExMem_MemWriteStage3   = 1'b0;
    ExMem_MemtoRegStage3   = 1'b0;
    ExMem_AluResult_Stage3 = '0;
    ExMem_ReadData2Bypass  = '0;
    ExMem_RdAddStage3      = '0;
  endtask

  task automatic model_reset();
    m_rw = 1'b0; m_m2r = 1'b0; m_rdata = '0; m_alu = '0; m_rd = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_valid"}, {31'd0, dmem_req_valid}, 32'd0);
    check({tag, " dmem_we"},   {31'd0, dmem_we}, 32'd0);
    check({tag, " dmem_addr"}, dmem_addr, 32'd0);
    check({tag, " dmem_wdata"}, dmem_wdata, 32'd0);
    check({tag, " misaligned"}, {31'd0, mem_misaligned}, 32'd0);
    check({tag, " stall"},     {31'd0, mem_stall}, 32'd0);
    check_memwb(tag);
  endtask

  vec_t vecs[8];

  initial begin
    //          rw    mr    mw    m2r   alu           wdata         rdata         rd    rdy rsp hold junk  (exp filled below)
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0,        32'h0,        5'd5,  0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 5'd7,  0, 0, 0, 1'b0, 3, 1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'hA5A5_A5A5, 32'h0,        5'd0,  4, 0, 0, 1'b1, 6, 5, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0102, 32'h0,        32'h1111_1111, 5'd9,  0, 0, 0, 1'b0, 0, 0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0,        32'h0BAD_F00D, 5'd12, 0, 2, 2, 1'b1, 5, 1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h1357_9BDF, 32'h7777_7777, 5'd3,  1, 0, 0, 1'b1, 3, 2, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0201, 32'h5555_0000, 32'h0,        5'd0,  0, 0, 0, 1'b0, 0, 0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,        32'h0,        5'd31, 0, 0, 2, 1'b1, 0, 0, 1'b0, 1'b1};

    rst = 1'b1;
    en_MemWb = 1'b1;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rdata = '0;
    drive_nop();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");

    foreach (vecs[i]) run_instr($sformatf("vec%0d", i), vecs[i]);

    // Random instruction stream against the model.
    for (int n = 0; n < 300; n++) begin
      vec_t v;
      int   op;
      op      = int'($urandom_range(0, 3));
      v.rw    = 1'($urandom);
      v.m2r   = 1'($urandom);
      v.mr    = (op == 1) || (op == 3);
      v.mw    = (op == 2) || (op == 3);
      v.alu   = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) v.alu[1:0] = 2'($urandom_range(1, 3));
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.rd    = 5'($urandom);
      v.ready_wait = int'($urandom_range(0, 3));
      v.rsp_wait   = int'($urandom_range(0, 3));
      v.en_hold    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      v.junk       = 1'($urandom);
      v = fill(v);
      run_instr($sformatf("rnd%0d", n), v);
    end

    // Reset while waiting for a load response; the late response must be ignored.
    ExMem_RegwriteStage3   = 1'b1;
    ExMem_MemReadStage3    = 1'b1;
    ExMem_MemWriteStage3   = 1'b0;
    ExMem_MemtoRegStage3   = 1'b1;
    ExMem_AluResult_Stage3 = 32'h0000_0400;
    ExMem_ReadData2Bypass  = '0;
    ExMem_RdAddStage3      = 5'd4;
    en_MemWb = 1'b1;
    @(negedge clk);
    check("abort detect stall", {31'd0, mem_stall}, 32'd1);
    @(posedge clk); #1;
    dmem_req_ready = 1'b1;
    @(negedge clk);
    check("abort req_valid", {31'd0, dmem_req_valid}, 32'd1);
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    rst = 1'b1;
    drive_nop();
    @(negedge clk);
    check("abort resp stall", {31'd0, mem_stall}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    dmem_rsp_valid = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    check("abort late rsp ignored", MemWb_ReadData, 32'd0);
    @(negedge clk);
    check("abort idle stall", {31'd0, mem_stall}, 32'd0);
    check("abort idle req_valid", {31'd0, dmem_req_valid}, 32'd0);

    // The stage must be fully usable again after the abort.
    @(posedge clk); #1;
    run_instr("post-abort load", fill('{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0500, 32'h0, 32'h2468_ACE0, 5'd6,
                                       0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
